// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions for the divide sequencer:
// funct3 codes and the FSM state encoding.
package rv32im_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] DIV_F3  = 3'b100;
  localparam logic [2:0] DIVU_F3 = 3'b101;
  localparam logic [2:0] REM_F3  = 3'b110;
  localparam logic [2:0] REMU_F3 = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVIDE = 2'b01,
    FIXUP  = 2'b10,
    DONE   = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX stage and the
// divide sequencer.
interface div_sequencer_if;
  import rv32im_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            kill;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  modport master (
    output start, funct3, operand_a, operand_b, kill,
    input  result, busy, done
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, kill,
    output result, busy, done
  );

endinterface

// File: rtl/div_sequencer_div_step.sv
// One radix-2 restoring divide iteration: shift the
// remainder/quotient pair left and try to subtract.
module div_step
  import rv32im_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] sh_rem;
  logic [XLEN:0] trial;

  // Shift, trial-subtract, restore on borrow.
  always_comb begin
    sh_rem = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
    trial  = sh_rem - {1'b0, div_i};
    rem_o  = sh_rem;
    quo_o  = {quo_i[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_o    = trial;
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: FSM, counter,
// sign latches and registered result.
module div_sequencer
  import rv32im_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  div_sequencer_if.slave  bus
);

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_rem_q, is_rem_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;

  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    sgn   = ~bus.funct3[0];
    a_neg = sgn & bus.operand_a[XLEN-1];
    b_neg = sgn & bus.operand_b[XLEN-1];
    abs_a = a_neg ? -bus.operand_a : bus.operand_a;
    abs_b = b_neg ? -bus.operand_b : bus.operand_b;
    fix_q = neg_q_q ? -quo_q : quo_q;
    fix_r = neg_r_q ? -rem_q[XLEN-1:0]
                    : rem_q[XLEN-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && bus.funct3[2] && !bus.kill) begin
          is_rem_d = bus.funct3[1];
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          if (bus.operand_b == '0) begin
            result_d = bus.funct3[1] ? bus.operand_a
                                     : '1;
            state_d  = DONE;
          end else if (sgn &&
                       bus.operand_a == 32'h8000_0000 &&
                       bus.operand_b == 32'hFFFF_FFFF) begin
            result_d = bus.funct3[1] ? '0
                                     : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = abs_a;
            dvs_d   = abs_b;
            cnt_d   = '0;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          result_d = is_rem_q ? fix_r : fix_q;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed ops push
// expected results; a monitor checks each done pulse.
module tb_div_sequencer;
  import rv32im_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          issue;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_tot;
  exp_t sb[$];

  div_sequencer_if bus ();

  div_sequencer dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  // Monitor: every done pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.funct3    = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.kill      = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct3    = f3;
    bus.operand_a = a;
    bus.operand_b = b;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) begin
      n_tot++;
      $display("FAIL %s_timeout: no done after %0d", nm, k);
    end else begin
      check({nm, "_busy_at_done"}, bus.busy, 1'b1);
    end
    @(negedge clk);
    check({nm, "_busy_after"}, bus.busy, 1'b0);
  endtask

  task automatic do_op(input string nm,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] r,
                       input int lat);
    exp_t e;
    issue(f3, a, b);
    e.res = r;
    e.lat = lat;
    e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
    idle_inputs();
    check({nm, "_busy_c1"}, bus.busy, 1'b1);
    wait_done(nm);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    cyc    = 0;
    rst    = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    do_op("divu_20_3", DIVU_F3, 20, 3, 6, 34);
    do_op("remu_20_3", REMU_F3, 20, 3, 2, 34);
    do_op("div_m7_2", DIV_F3, 32'hFFFF_FFF9, 2,
          32'hFFFF_FFFD, 34);
    do_op("rem_m7_2", REM_F3, 32'hFFFF_FFF9, 2,
          32'hFFFF_FFFF, 34);
    do_op("rem_7_m2", REM_F3, 7, 32'hFFFF_FFFE, 1, 34);
    do_op("divu_max_1", DIVU_F3, 32'hFFFF_FFFF, 1,
          32'hFFFF_FFFF, 34);
    do_op("divu_x_0", DIVU_F3, 32'h1234, 0,
          32'hFFFF_FFFF, 1);
    do_op("rem_x_0", REM_F3, 32'h1234, 0, 32'h1234, 1);
    do_op("div_ovf", DIV_F3, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf", REM_F3, 32'h8000_0000,
          32'hFFFF_FFFF, 32'h0, 1);

    // funct3[2]=0: request must be ignored.
    issue(3'b000, 9, 3);
    @(negedge clk);
    idle_inputs();
    check("nondiv_busy", bus.busy, 1'b0);

    // Second start mid-operation is ignored.
    begin
      exp_t e;
      issue(DIV_F3, 100, 32'hFFFF_FFF9);
      e.res = 32'hFFFF_FFF2;
      e.lat = 34;
      e.issue = cyc;
      sb.push_back(e);
      @(negedge clk);
      idle_inputs();
      repeat (5) @(negedge clk);
      bus.start     = 1'b1;
      bus.funct3    = DIVU_F3;
      bus.operand_a = 50;
      bus.operand_b = 5;
      @(negedge clk);
      idle_inputs();
      wait_done("ignore2nd");
    end

    // Kill at iteration 10.
    issue(DIVU_F3, 1000, 3);
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy", bus.busy, 1'b0);
    repeat (40) @(negedge clk);
    check("kill_result", bus.result, 32'hFFFF_FFF2);
    check("kill_busy_late", bus.busy, 1'b0);

    // Reset at iteration 20.
    issue(DIVU_F3, 1000, 3);
    @(negedge clk);
    idle_inputs();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_result", bus.result, 32'h0);
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_done", bus.done, 1'b0);
    repeat (40) @(negedge clk);
    do_op("divu_100_7", DIVU_F3, 100, 7, 14, 34);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL missing_done: %0d pending", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
